// File: rtl/T_bird_tail_light_FSM_pkg.sv
// Shared types and helpers for the T-bird tail-light FSM and its stimulus generator.
// T_BIRD_STIM_MULTI_REQ_EN enables simultaneous request combinations for command codes 4-6.
package T_bird_tail_light_FSM_pkg;

  localparam int LFSR_W = 8;

  typedef enum logic [2:0] {
    GEN_IDLE,
    GEN_LOAD,
    GEN_HOLD,
    GEN_DRAIN,
    GEN_DONE
  } gen_state_t;

  typedef enum logic [2:0] {
    CMD_NONE       = 3'd0,
    CMD_LEFT       = 3'd1,
    CMD_RIGHT      = 3'd2,
    CMD_HAZ        = 3'd3,
    CMD_LEFT_RIGHT = 3'd4,
    CMD_LEFT_HAZ   = 3'd5,
    CMD_RIGHT_HAZ  = 3'd6,
    CMD_NONE_ALT   = 3'd7
  } cmd_t;

  typedef struct packed {
    logic left;
    logic right;
    logic haz;
  } req_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic req_t cmd_decode(input cmd_t c);
    req_t r;
    r = '0;
    case (c)
      CMD_LEFT:       r.left  = 1'b1;
      CMD_RIGHT:      r.right = 1'b1;
      CMD_HAZ:        r.haz   = 1'b1;
`ifdef T_BIRD_STIM_MULTI_REQ_EN
      CMD_LEFT_RIGHT: begin r.left  = 1'b1; r.right = 1'b1; end
      CMD_LEFT_HAZ:   begin r.left  = 1'b1; r.haz   = 1'b1; end
      CMD_RIGHT_HAZ:  begin r.right = 1'b1; r.haz   = 1'b1; end
`else
      // Single-request build folds the combination codes onto one request each.
      CMD_LEFT_RIGHT: r.left  = 1'b1;
      CMD_LEFT_HAZ:   r.right = 1'b1;
      CMD_RIGHT_HAZ:  r.haz   = 1'b1;
`endif
      default:        r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/t_bird_lfsr8.sv
// 8-bit Fibonacci LFSR, reset to SEED, advancing one step per enabled cycle.
module t_bird_lfsr8
  import T_bird_tail_light_FSM_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  output logic [LFSR_W-1:0] value_o
);

  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/t_bird_stim_gen.sv
// Closed-loop stimulus generator driving left/right/haz into the T-bird tail-light FSM.
// T_BIRD_STIM_MULTI_REQ_EN (package) selects multi-request command decoding.
module t_bird_stim_gen
  import T_bird_tail_light_FSM_pkg::*;
#(
  parameter int                NUM_CMDS      = 64,
  parameter int                HOLD_W        = 4,
  parameter logic [LFSR_W-1:0] SEED          = 8'hA5,
  parameter int                DRAIN_TIMEOUT = 16,
  localparam int               CNT_W         = $clog2(NUM_CMDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             fsm_idle,
  output logic             left,
  output logic             right,
  output logic             haz,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cmd_count
);

  localparam int               DRN_W      = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] NUM_CMDS_C = CNT_W'(NUM_CMDS);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);

  gen_state_t        state_q, state_d;
  req_t              req_q, req_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              terr_q, terr_d;
  logic              lfsr_en;
  logic [LFSR_W-1:0] lfsr_val;
  logic [LFSR_W-1:0] lfsr_adv;
  logic              unused_lfsr;

  t_bird_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (lfsr_en),
    .value_o (lfsr_val)
  );

  // Command is decoded from the value the LFSR steps to at the end of GEN_LOAD.
  assign lfsr_adv    = lfsr_next(lfsr_val);
  assign unused_lfsr = ^lfsr_adv;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    hold_d  = hold_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    terr_d  = terr_q;
    lfsr_en = 1'b0;
    case (state_q)
      GEN_IDLE, GEN_DONE: begin
        if (start) begin
          state_d = GEN_LOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          terr_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      GEN_LOAD: begin
        lfsr_en = 1'b1;
        req_d   = cmd_decode(cmd_t'(lfsr_adv[2:0]));
        hold_d  = lfsr_adv[HOLD_W+3:4];
        if (cnt_q != NUM_CMDS_C) cnt_d = cnt_q + 1'b1;
        state_d = GEN_HOLD;
      end
      GEN_HOLD: begin
        if (hold_q == '0) begin
          req_d   = '0;
          drain_d = '0;
          state_d = GEN_DRAIN;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      GEN_DRAIN: begin
        // Idle takes precedence over a timeout landing in the same cycle.
        if (fsm_idle || (drain_q == DRAIN_LAST)) begin
          if (!fsm_idle) terr_d = 1'b1;
          if (cnt_q == NUM_CMDS_C) begin
            state_d = GEN_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = GEN_LOAD;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = GEN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GEN_IDLE;
      req_q   <= '0;
      hold_q  <= '0;
      drain_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  assign left        = req_q.left;
  assign right       = req_q.right;
  assign haz         = req_q.haz;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign cmd_count   = cnt_q;

endmodule

// File: tb/tb_t_bird_stim_gen.sv
// Directed bench for t_bird_stim_gen: a NUM_CMDS=1 instance and a NUM_CMDS=64 instance.
module tb_t_bird_stim_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start1 = 1'b0, idle1 = 1'b1;
  logic       left1, right1, haz1, busy1, done1, terr1;
  logic [0:0] cmd_count1;

  logic       start64 = 1'b0, idle64 = 1'b0;
  logic       left64, right64, haz64, busy64, done64, terr64;
  logic [6:0] cmd_count64;

  int errors = 0;
  int checks = 0;
  logic [7:0] m64 = 8'hA5;
`ifdef T_BIRD_STIM_MULTI_REQ_EN
  int lh_seen = 0;
`endif

  t_bird_stim_gen #(.NUM_CMDS(1), .HOLD_W(4), .SEED(8'hA5), .DRAIN_TIMEOUT(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .fsm_idle(idle1),
    .left(left1), .right(right1), .haz(haz1), .busy(busy1), .done(done1),
    .timeout_err(terr1), .cmd_count(cmd_count1)
  );

  t_bird_stim_gen #(.NUM_CMDS(64), .HOLD_W(4), .SEED(8'hA5), .DRAIN_TIMEOUT(16)) u64 (
    .clk(clk), .rst(rst), .start(start64), .fsm_idle(idle64),
    .left(left64), .right(right64), .haz(haz64), .busy(busy64), .done(done64),
    .timeout_err(terr64), .cmd_count(cmd_count64)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Expected {left,right,haz} for a command code.
  function automatic logic [2:0] exp_req(input logic [2:0] code);
    case (code)
      3'd1: return 3'b100;
      3'd2: return 3'b010;
      3'd3: return 3'b001;
`ifdef T_BIRD_STIM_MULTI_REQ_EN
      3'd4: return 3'b110;
      3'd5: return 3'b101;
      3'd6: return 3'b011;
`else
      3'd4: return 3'b100;
      3'd5: return 3'b010;
      3'd6: return 3'b001;
`endif
      default: return 3'b000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({left1, right1, haz1, busy1, done1, terr1} !== 6'b0 || cmd_count1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_u1 outputs=%b cmd_count=%0d required all 0", {left1, right1, haz1, busy1, done1, terr1}, cmd_count1);
    end
    checks++;
    if ({left64, right64, haz64, busy64, done64, terr64} !== 6'b0 || cmd_count64 !== 7'd0) begin
      errors++;
      $display("FAIL reset_u64 outputs=%b cmd_count=%0d required all 0", {left64, right64, haz64, busy64, done64, terr64}, cmd_count64);
    end
  endtask

  task automatic test_single_cmd();
    int n;
    start1 = 1'b1; tick(); start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || {left1, right1, haz1} !== 3'b000) begin
      errors++;
      $display("FAIL single_load busy=%b req=%b required busy=1 req=000", busy1, {left1, right1, haz1});
    end
    tick();
    checks++;
    if ({left1, right1, haz1} !== 3'b010 || cmd_count1 !== 1'b1) begin
      errors++;
      $display("FAIL single_right req=%b cmd_count=%0d required req=010 cmd_count=1", {left1, right1, haz1}, cmd_count1);
    end
    n = 0;
    while (right1 === 1'b1 && n < 40) begin n++; tick(); end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL single_hold right high %0d cycles required 5", n);
    end
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL single_drain done=%b busy=%b required done=0 busy=1", done1, busy1);
    end
    tick();
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || cmd_count1 !== 1'b1) begin
      errors++;
      $display("FAIL done_latency done=%b busy=%b cmd_count=%0d required 1 0 1", done1, busy1, cmd_count1);
    end
  endtask

  task automatic u1_run(input logic [7:0] v);
    int n;
    logic [2:0] e;
    e = exp_req(v[2:0]);
    start1 = 1'b1; tick(); start1 = 1'b0;
    checks++;
    if (cmd_count1 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL restart_load v=%h cmd_count=%0d done=%b busy=%b required 0 0 1", v, cmd_count1, done1, busy1);
    end
    tick();
    checks++;
    if ({left1, right1, haz1} !== e || cmd_count1 !== 1'b1) begin
      errors++;
      $display("FAIL restart_cmd v=%h req=%b cmd_count=%0d required req=%b cmd_count=1", v, {left1, right1, haz1}, cmd_count1, e);
    end
    n = 0;
    while ({left1, right1, haz1} === e && n < 40) begin n++; tick(); end
    checks++;
    if (n != int'(v[7:4]) + 1) begin
      errors++;
      $display("FAIL restart_hold v=%h held %0d cycles required %0d", v, n, int'(v[7:4]) + 1);
    end
    tick();
    checks++;
    if (done1 !== 1'b1) begin
      errors++;
      $display("FAIL restart_done v=%h done=%b required 1", v, done1);
    end
  endtask

  task automatic test_restart();
    u1_run(8'h95);
    u1_run(8'h2A);
  endtask

  task automatic test_async_reset();
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick();
    checks++;
    if (left1 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_left left=%b required 1", left1);
    end
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({left1, right1, haz1, busy1, done1, terr1} !== 6'b0 || cmd_count1 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset outputs=%b cmd_count=%0d required all 0", {left1, right1, haz1, busy1, done1, terr1}, cmd_count1);
    end
    #1 rst = 1'b0;
    tick();
    u1_run(8'h4A);
  endtask

  task automatic test_timeout();
    int n;
    start64 = 1'b1; tick(); start64 = 1'b0;
    n = 0;
    while (right64 !== 1'b1 && n < 10) begin n++; tick(); end
    m64 = lfsr_step(m64);
    checks++;
    if ({left64, right64, haz64} !== exp_req(m64[2:0]) || cmd_count64 !== 7'd1) begin
      errors++;
      $display("FAIL to_first_cmd req=%b cmd_count=%0d required req=%b cmd_count=1", {left64, right64, haz64}, cmd_count64, exp_req(m64[2:0]));
    end
    n = 0;
    while (right64 === 1'b1 && n < 40) begin n++; tick(); end
    n = 0;
    while (terr64 !== 1'b1 && n < 40) begin n++; tick(); end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL timeout_cycles timeout_err after %0d drain cycles required 16", n);
    end
    checks++;
    if (cmd_count64 !== 7'd1 || busy64 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_load cmd_count=%0d busy=%b required 1 1", cmd_count64, busy64);
    end
    idle64 = 1'b1;
    tick();
    m64 = lfsr_step(m64);
    checks++;
    if (cmd_count64 !== 7'd2 || {left64, right64, haz64} !== exp_req(m64[2:0]) || terr64 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next cmd_count=%0d req=%b err=%b required 2 %b 1", cmd_count64, {left64, right64, haz64}, terr64, exp_req(m64[2:0]));
    end
  endtask

  task automatic test_start_ignored();
    start64 = 1'b1; tick(); start64 = 1'b0;
    checks++;
    if (cmd_count64 !== 7'd2 || busy64 !== 1'b1 || {left64, right64, haz64} !== exp_req(m64[2:0])) begin
      errors++;
      $display("FAIL start_ignored cmd_count=%0d busy=%b req=%b required 2 1 %b", cmd_count64, busy64, {left64, right64, haz64}, exp_req(m64[2:0]));
    end
  endtask

  // Follows the u64 run from command first_k to the end against the LFSR model.
  task automatic run_cmds(input int first_k);
    for (int k = first_k; k <= 64; k++) begin
      int w, n, hold;
      logic [2:0] e, obs;
      bit shape_bad;
      w = 0;
      while (cmd_count64 !== 7'(k) && w < 40) begin w++; tick(); end
      checks++;
      if (cmd_count64 !== 7'(k)) begin
        errors++;
        $display("FAIL cmd_wait cmd_count=%0d required %0d", cmd_count64, k);
        return;
      end
      m64 = lfsr_step(m64);
      e = exp_req(m64[2:0]);
      hold = int'(m64[7:4]) + 1;
      shape_bad = 1'b0;
      n = 0;
      do begin
        obs = {left64, right64, haz64};
        if ((n < hold) ? (obs !== e) : (obs !== 3'b000)) shape_bad = 1'b1;
`ifdef T_BIRD_STIM_MULTI_REQ_EN
        if (obs === 3'b101) lh_seen++;
`else
        checks++;
        if ($countones(obs) > 1) begin
          errors++;
          $display("FAIL one_hot cmd=%0d req=%b required at most one bit", k, obs);
        end
`endif
        n++;
        tick();
      end while (cmd_count64 === 7'(k) && done64 !== 1'b1 && n < 40);
      checks++;
      if (shape_bad) begin
        errors++;
        $display("FAIL hold_shape cmd=%0d lfsr=%h req pattern differs from %b for %0d cycles", k, m64, e, hold);
      end
      checks++;
      if (n != ((k == 64) ? hold + 1 : hold + 2)) begin
        errors++;
        $display("FAIL cmd_interval cmd=%0d cycles=%0d required %0d", k, n, (k == 64) ? hold + 1 : hold + 2);
      end
    end
    checks++;
    if (done64 !== 1'b1 || busy64 !== 1'b0 || cmd_count64 !== 7'd64) begin
      errors++;
      $display("FAIL run_done done=%b busy=%b cmd_count=%0d required 1 0 64", done64, busy64, cmd_count64);
    end
  endtask

  task automatic test_run_to_done();
    run_cmds(3);
    checks++;
    if (terr64 !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky timeout_err=%b required 1", terr64);
    end
  endtask

  task automatic test_long_run();
    for (int r = 0; r < 8; r++) begin
      start64 = 1'b1; tick(); start64 = 1'b0;
      checks++;
      if (cmd_count64 !== 7'd0 || done64 !== 1'b0 || busy64 !== 1'b1 || terr64 !== 1'b0) begin
        errors++;
        $display("FAIL rerun_start run=%0d cmd_count=%0d done=%b busy=%b err=%b required 0 0 1 0", r, cmd_count64, done64, busy64, terr64);
      end
      run_cmds(1);
    end
`ifdef T_BIRD_STIM_MULTI_REQ_EN
    checks++;
    if (lh_seen == 0) begin
      errors++;
      $display("FAIL left_haz_seen count=%0d required >0", lh_seen);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_cmd();
    test_restart();
    test_async_reset();
    test_timeout();
    test_start_ignored();
    test_run_to_done();
    test_long_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
